// File: rtl/memory_controller_if.sv
// Bus bundle between the memory controller, the LSB, the fetcher and RAM.
// The controller owns the slave view; requesters and RAM sit on master.
interface memory_controller_if #(
  parameter int LSB_CAP_BIT = 3
);
  logic                   lsb_req;
  logic [LSB_CAP_BIT-1:0] lsb_pos;
  logic                   lsb_ls;
  logic [1:0]             lsb_len;
  logic [31:0]            lsb_addr;
  logic [31:0]            lsb_val;
  logic                   mem_busy;
  logic                   mem_finished;
  logic [31:0]            mem_val;
  logic [LSB_CAP_BIT-1:0] mem_pos;
  logic                   if_req;
  logic [31:0]            if_addr;
  logic                   if_ready;
  logic [31:0]            if_inst;
  logic [7:0]             mem_din;
  logic [7:0]             mem_dout;
  logic [31:0]            mem_a;
  logic                   mem_wr;

  modport slave (
    input  lsb_req, lsb_pos, lsb_ls, lsb_len,
    input  lsb_addr, lsb_val,
    input  if_req, if_addr, mem_din,
    output mem_busy, mem_finished, mem_val, mem_pos,
    output if_ready, if_inst,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output lsb_req, lsb_pos, lsb_ls, lsb_len,
    output lsb_addr, lsb_val,
    output if_req, if_addr, mem_din,
    input  mem_busy, mem_finished, mem_val, mem_pos,
    input  if_ready, if_inst,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/memory_controller.sv
// Serialises LSB loads/stores and word fetches onto a byte-wide RAM
// with 1-cycle read latency; one completion pulse per access.
module memory_controller #(
  parameter int LSB_CAP_BIT = 3
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic clear,
  memory_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t state, state_n;

  logic [2:0]  k, k_n;
  logic [2:0]  n, n_n;
  logic [31:0] a_q, a_n;
  logic [31:0] wdat, wdat_n;
  logic [31:0] rbuf, rbuf_n;
  logic [31:0] val_q, val_n;
  logic [31:0] inst_q, inst_n;
  logic [7:0]  dout_q, dout_n;
  logic        wr_q, wr_n;
  logic        fin_q, fin_n;
  logic        ifr_q, ifr_n;
  logic        is_if, is_if_n;
  logic        squash, squash_n;
  logic [LSB_CAP_BIT-1:0] pos_q, pos_n;

  logic        rdy_q;
  logic [7:0]  din_hold;
  logic [7:0]  din;
  logic [1:0]  bi;

  function automatic logic [2:0] len2n(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // RAM keeps returning data while paused; keep the byte that belongs
  // to the last active cycle so a resumed read captures the right one.
  assign din = rdy_q ? bus.mem_din : din_hold;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdy_q    <= 1'b0;
      din_hold <= 8'h00;
    end else begin
      rdy_q <= rdy_in;
      if (rdy_q) din_hold <= bus.mem_din;
    end
  end

  always_comb begin
    state_n  = state;
    k_n      = k;
    n_n      = n;
    a_n      = a_q;
    wdat_n   = wdat;
    rbuf_n   = rbuf;
    val_n    = val_q;
    inst_n   = inst_q;
    dout_n   = dout_q;
    wr_n     = wr_q;
    fin_n    = 1'b0;
    ifr_n    = 1'b0;
    is_if_n  = is_if;
    squash_n = squash;
    pos_n    = pos_q;
    bi       = 2'(k - 3'd1);
    unique case (state)
      IDLE: begin
        if (!clear) begin
          if (bus.lsb_req) begin
            state_n  = bus.lsb_ls ? WRITE : READ;
            n_n      = len2n(bus.lsb_len);
            k_n      = 3'd0;
            a_n      = bus.lsb_addr;
            pos_n    = bus.lsb_pos;
            is_if_n  = 1'b0;
            squash_n = 1'b0;
            rbuf_n   = 32'h0;
            wr_n     = bus.lsb_ls;
            wdat_n   = {8'h00, bus.lsb_val[31:8]};
            if (bus.lsb_ls) dout_n = bus.lsb_val[7:0];
          end else if (bus.if_req) begin
            state_n  = READ;
            n_n      = 3'd4;
            k_n      = 3'd0;
            a_n      = bus.if_addr;
            is_if_n  = 1'b1;
            squash_n = 1'b0;
            rbuf_n   = 32'h0;
            wr_n     = 1'b0;
          end
        end
      end
      READ: begin
        if (k != 3'd0) rbuf_n[{bi, 3'b000} +: 8] = din;
        if (clear) begin
          state_n = IDLE;
        end else if (k == n) begin
          state_n = IDLE;
          if (is_if) begin
            ifr_n  = 1'b1;
            inst_n = rbuf_n;
          end else begin
            fin_n = 1'b1;
            val_n = rbuf_n;
          end
        end else begin
          k_n = k + 3'd1;
          if (k + 3'd1 < n) a_n = a_q + 32'd1;
        end
      end
      WRITE: begin
        // a flushed store still finishes so RAM never holds a torn word
        squash_n = squash | clear;
        if (k == n - 3'd1) begin
          state_n = IDLE;
          wr_n    = 1'b0;
          val_n   = 32'h0;
          fin_n   = !(squash | clear);
        end else begin
          k_n    = k + 3'd1;
          a_n    = a_q + 32'd1;
          dout_n = wdat[7:0];
          wdat_n = {8'h00, wdat[31:8]};
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      k      <= 3'd0;
      n      <= 3'd0;
      a_q    <= 32'h0;
      wdat   <= 32'h0;
      rbuf   <= 32'h0;
      val_q  <= 32'h0;
      inst_q <= 32'h0;
      dout_q <= 8'h00;
      wr_q   <= 1'b0;
      fin_q  <= 1'b0;
      ifr_q  <= 1'b0;
      is_if  <= 1'b0;
      squash <= 1'b0;
      pos_q  <= '0;
    end else if (rdy_in) begin
      state  <= state_n;
      k      <= k_n;
      n      <= n_n;
      a_q    <= a_n;
      wdat   <= wdat_n;
      rbuf   <= rbuf_n;
      val_q  <= val_n;
      inst_q <= inst_n;
      dout_q <= dout_n;
      wr_q   <= wr_n;
      fin_q  <= fin_n;
      ifr_q  <= ifr_n;
      is_if  <= is_if_n;
      squash <= squash_n;
      pos_q  <= pos_n;
    end
  end

  assign bus.mem_busy = (state != IDLE) | bus.lsb_req
                      | (bus.if_req & (state == IDLE));
  assign bus.mem_finished = fin_q & ~clear;
  assign bus.if_ready     = ifr_q & ~clear;
  assign bus.mem_val      = val_q;
  assign bus.mem_pos      = pos_q;
  assign bus.if_inst      = inst_q;
  assign bus.mem_a        = a_q;
  assign bus.mem_dout     = dout_q;
  assign bus.mem_wr       = wr_q;

endmodule

// File: tb/tb_memory_controller.sv
// Randomised bench for memory_controller against a byte-level memory
// model with access timing computed from byte counts.
module tb_memory_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  int checks = 0;
  int errors = 0;

  memory_controller_if #(.LSB_CAP_BIT(3)) bus ();

  memory_controller #(.LSB_CAP_BIT(3)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .rdy_in(rdy),
    .clear(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_b(input logic [31:0] a);
    return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'hA5;
  endfunction

  bit [7:0] ram [65536];
  bit       wrt [65536];

  always @(posedge clk) begin
    if (bus.mem_wr) begin
      ram[bus.mem_a[15:0]] <= bus.mem_dout;
      wrt[bus.mem_a[15:0]] <= 1'b1;
    end
    bus.mem_din <= wrt[bus.mem_a[15:0]] ? ram[bus.mem_a[15:0]]
                                        : init_b(bus.mem_a);
  end

  logic [7:0] mdl [logic [31:0]];

  function automatic logic [7:0] m_rd(input logic [31:0] a);
    if (mdl.exists(a)) return mdl[a];
    return init_b(a);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = m_rd(a + 32'(i));
    return r;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) mdl[a + 32'(i)] = v[8*i +: 8];
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // issue one LSB request and watch it; cycle 1 is the first after accept
  task automatic access(
    input bit ls, input logic [1:0] len, input logic [31:0] a,
    input logic [31:0] v, input logic [2:0] pos,
    input int st_at, input int st_len, input int clr_at, input int maxc,
    output int lat, output logic [31:0] rv, output logic [2:0] rp,
    output bit tr_ok);
    int n;
    n = nbytes(len);
    lat = -1;
    rv = 32'h0;
    rp = 3'h0;
    tr_ok = 1'b1;
    cyc();
    bus.lsb_req = 1'b1;
    bus.lsb_ls = ls;
    bus.lsb_len = len;
    bus.lsb_addr = a;
    bus.lsb_val = v;
    bus.lsb_pos = pos;
    for (int c = 1; c <= maxc; c++) begin
      cyc();
      bus.lsb_req = 1'b0;
      rdy = !(c >= st_at && c < st_at + st_len);
      clr = (c == clr_at);
      #1;
      if (c <= n) begin
        if (bus.mem_a !== a + 32'(c - 1) || bus.mem_wr !== ls
            || (ls && bus.mem_dout !== v[8*(c-1) +: 8]))
          tr_ok = 1'b0;
      end else if (bus.mem_wr !== 1'b0) begin
        tr_ok = 1'b0;
      end
      if (bus.mem_finished === 1'b1) begin
        lat = c;
        rv = bus.mem_val;
        rp = bus.mem_pos;
        break;
      end
    end
    rdy = 1'b1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.lsb_req = 1'b0;
    bus.lsb_pos = 3'h0;
    bus.lsb_ls = 1'b0;
    bus.lsb_len = 2'b00;
    bus.lsb_addr = 32'h0;
    bus.lsb_val = 32'h0;
    bus.if_req = 1'b0;
    bus.if_addr = 32'h0;
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({bus.mem_finished, bus.if_ready, bus.mem_wr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses got %b want 000",
               {bus.mem_finished, bus.if_ready, bus.mem_wr});
    end
    checks++;
    if ({bus.mem_a, bus.mem_dout} !== 40'h0) begin
      errors++;
      $display("FAIL reset_ram_port got %h/%h want 0/0", bus.mem_a, bus.mem_dout);
    end
    checks++;
    if ({bus.mem_val, bus.if_inst, bus.mem_pos} !== 67'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h want 0", bus.mem_val,
               bus.if_inst, bus.mem_pos);
    end
    checks++;
    if (bus.mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", bus.mem_busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_basic();
    int lat;
    logic [31:0] rv;
    logic [2:0] rp;
    bit tr;
    access(1'b1, 2'b10, 32'h100, 32'h44332211, 3'd1, 0, 0, 0, 10, lat, rv, rp, tr);
    m_store(32'h100, 32'h44332211, 4);
    checks++;
    if (lat !== 5 || !tr || rv !== 32'h0 || rp !== 3'd1) begin
      errors++;
      $display("FAIL sw_basic lat=%0d tr=%0d val=%h pos=%0d want 5/1/0/1",
               lat, tr, rv, rp);
    end
    access(1'b1, 2'b01, 32'h202, 32'hABCD1234, 3'd2, 0, 0, 0, 10, lat, rv, rp, tr);
    m_store(32'h202, 32'hABCD1234, 2);
    checks++;
    if (lat !== 3 || !tr || rv !== 32'h0 || rp !== 3'd2) begin
      errors++;
      $display("FAIL sh_basic lat=%0d tr=%0d val=%h pos=%0d want 3/1/0/2",
               lat, tr, rv, rp);
    end
  endtask

  task automatic test_load_basic();
    int lat;
    logic [31:0] rv;
    logic [2:0] rp;
    bit tr;
    access(1'b0, 2'b10, 32'h100, 32'h0, 3'd5, 0, 0, 0, 12, lat, rv, rp, tr);
    checks++;
    if (lat !== 6 || !tr || rp !== 3'd5) begin
      errors++;
      $display("FAIL lw_timing lat=%0d tr=%0d pos=%0d want 6/1/5", lat, tr, rp);
    end
    checks++;
    if (rv !== m_load(32'h100, 4)) begin
      errors++;
      $display("FAIL lw_value got %h want %h", rv, m_load(32'h100, 4));
    end
  endtask

  task automatic test_random();
    int lat, n, xl;
    logic [31:0] rv, a, v, xv;
    logic [2:0] rp, pos;
    logic [1:0] len;
    bit tr, ls;
    for (int i = 0; i < 24; i++) begin
      ls = 1'($urandom_range(0, 1));
      len = 2'($urandom_range(0, 2));
      n = nbytes(len);
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                       : 32'h300 + $urandom_range(0, 63);
      v = $urandom;
      pos = 3'($urandom_range(0, 7));
      xl = ls ? n + 1 : n + 2;
      xv = ls ? 32'h0 : m_load(a, n);
      access(ls, len, a, v, pos, 0, 0, 0, 12, lat, rv, rp, tr);
      if (ls) m_store(a, v, n);
      checks++;
      if (lat !== xl) begin
        errors++;
        $display("FAIL rnd_lat[%0d] got %0d want %0d", i, lat, xl);
      end
      checks++;
      if (!tr) begin
        errors++;
        $display("FAIL rnd_trace[%0d] got bad bus sequence want addr %h+k", i, a);
      end
      checks++;
      if (rv !== xv) begin
        errors++;
        $display("FAIL rnd_val[%0d] got %h want %h", i, rv, xv);
      end
      checks++;
      if (rp !== pos) begin
        errors++;
        $display("FAIL rnd_pos[%0d] got %0d want %0d", i, rp, pos);
      end
    end
  endtask

  task automatic test_priority();
    int tf, ti, both;
    logic [31:0] v, inst;
    logic [2:0] p;
    tf = -1;
    ti = -1;
    both = 0;
    v = 32'h0;
    inst = 32'h0;
    p = 3'h0;
    cyc();
    bus.lsb_req = 1'b1;
    bus.lsb_ls = 1'b0;
    bus.lsb_len = 2'b00;
    bus.lsb_addr = 32'h10;
    bus.lsb_pos = 3'd3;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      bus.lsb_req = 1'b0;
      #1;
      if (bus.mem_finished && bus.if_ready) both++;
      if (bus.mem_finished === 1'b1) begin
        tf = c;
        v = bus.mem_val;
        p = bus.mem_pos;
      end
      if (bus.if_ready === 1'b1) begin
        ti = c;
        inst = bus.if_inst;
        bus.if_req = 1'b0;
        break;
      end
    end
    bus.if_req = 1'b0;
    checks++;
    if (tf !== 3 || v !== m_load(32'h10, 1) || p !== 3'd3) begin
      errors++;
      $display("FAIL prio_lb at=%0d val=%h pos=%0d want 3/%h/3",
               tf, v, p, m_load(32'h10, 1));
    end
    checks++;
    if (ti !== 9 || inst !== m_load(32'h0, 4)) begin
      errors++;
      $display("FAIL prio_fetch at=%0d inst=%h want 9/%h", ti, inst,
               m_load(32'h0, 4));
    end
    checks++;
    if (both !== 0) begin
      errors++;
      $display("FAIL prio_overlap got %0d want 0", both);
    end
  endtask

  task automatic test_clear_fetch();
    int got, wr;
    logic busy4;
    got = 0;
    wr = 0;
    busy4 = 1'b1;
    cyc();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      clr = (c == 3);
      if (c == 3) bus.if_req = 1'b0;
      #1;
      if (bus.if_ready === 1'b1) got++;
      if (bus.mem_wr === 1'b1) wr++;
      if (c == 4) busy4 = bus.mem_busy;
    end
    clr = 1'b0;
    checks++;
    if (got !== 0 || wr !== 0) begin
      errors++;
      $display("FAIL clr_fetch if_ready=%0d mem_wr=%0d want 0/0", got, wr);
    end
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("FAIL clr_fetch_idle busy=%b want 0", busy4);
    end
  endtask

  task automatic test_clear_misc();
    int lat, fin;
    logic [31:0] rv, v;
    logic [2:0] rp;
    bit tr;
    access(1'b0, 2'b00, 32'h20, 32'h0, 3'd1, 0, 0, 3, 8, lat, rv, rp, tr);
    checks++;
    if (lat !== -1) begin
      errors++;
      $display("FAIL clr_on_pulse got pulse at %0d want none", lat);
    end
    access(1'b0, 2'b10, 32'h100, 32'h0, 3'd1, 0, 0, 3, 10, lat, rv, rp, tr);
    checks++;
    if (lat !== -1) begin
      errors++;
      $display("FAIL clr_load got pulse at %0d want none", lat);
    end
    v = $urandom;
    access(1'b1, 2'b10, 32'h500, v, 3'd2, 0, 0, 2, 10, lat, rv, rp, tr);
    m_store(32'h500, v, 4);
    checks++;
    if (lat !== -1 || !tr) begin
      errors++;
      $display("FAIL clr_store pulse=%0d tr=%0d want -1/1", lat, tr);
    end
    access(1'b0, 2'b10, 32'h500, 32'h0, 3'd4, 0, 0, 0, 12, lat, rv, rp, tr);
    checks++;
    if (lat !== 6 || rv !== m_load(32'h500, 4)) begin
      errors++;
      $display("FAIL clr_store_data lat=%0d val=%h want 6/%h", lat, rv,
               m_load(32'h500, 4));
    end
    cyc();
    bus.lsb_req = 1'b1;
    bus.lsb_ls = 1'b1;
    bus.lsb_len = 2'b10;
    bus.lsb_addr = 32'h600;
    clr = 1'b1;
    cyc();
    bus.lsb_req = 1'b0;
    clr = 1'b0;
    #1;
    checks++;
    if (bus.mem_busy !== 1'b0 || bus.mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle_req busy=%b wr=%b want 0/0", bus.mem_busy,
               bus.mem_wr);
    end
    fin = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (bus.mem_finished === 1'b1 || bus.mem_wr === 1'b1) fin++;
    end
    checks++;
    if (fin !== 0) begin
      errors++;
      $display("FAIL clr_idle_quiet got %0d events want 0", fin);
    end
  endtask

  task automatic test_reset_mid();
    int ev;
    logic [31:0] v;
    logic w2;
    v = $urandom;
    cyc();
    bus.lsb_req = 1'b1;
    bus.lsb_ls = 1'b1;
    bus.lsb_len = 2'b10;
    bus.lsb_addr = 32'h400;
    bus.lsb_val = v;
    bus.lsb_pos = 3'd4;
    cyc();
    bus.lsb_req = 1'b0;
    cyc();
    w2 = bus.mem_wr;
    rst_n = 1'b0;
    #1;
    checks++;
    if (w2 !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid before=%b wr=%b busy=%b want 1/0/0", w2,
               bus.mem_wr, bus.mem_busy);
    end
    mdl[32'h400] = v[7:0];
    cyc();
    rst_n = 1'b1;
    ev = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (bus.mem_finished === 1'b1 || bus.mem_wr === 1'b1) ev++;
    end
    checks++;
    if (ev !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet got %0d events want 0", ev);
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [31:0] rv;
    logic [2:0] rp;
    bit tr;
    access(1'b0, 2'b10, 32'h100, 32'h0, 3'd6, 2, 3, 0, 20, lat, rv, rp, tr);
    checks++;
    if (lat !== 9 || rv !== m_load(32'h100, 4) || rp !== 3'd6) begin
      errors++;
      $display("FAIL stall_lw lat=%0d val=%h pos=%0d want 9/%h/6", lat, rv,
               rp, m_load(32'h100, 4));
    end
    access(1'b0, 2'b01, 32'h202, 32'h0, 3'd7, 3, 1, 0, 20, lat, rv, rp, tr);
    checks++;
    if (lat !== 5 || rv !== m_load(32'h202, 2)) begin
      errors++;
      $display("FAIL stall_lh lat=%0d val=%h want 5/%h", lat, rv,
               m_load(32'h202, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_basic();
    test_load_basic();
    test_priority();
    test_clear_fetch();
    test_clear_misc();
    test_reset_mid();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
